// File: rtl/spi_controller_if.sv
// Request/response handshake between a frame requester and spi_controller.
// The master modport is the requester; the slave modport is the controller.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;

  modport master (
    output req_valid, req_write, req_addr, req_data,
    input  req_ready, busy, done, rd_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data,
    output req_ready, busy, done, rd_data
  );
endinterface

// File: rtl/spi_controller.sv
// Mode-0 SPI frame controller: 16-bit frame {write, addr[6:0], data[7:0]}, MSB first.
// Optional CIPO capture into rd_data is enabled by defining SPI_CTRL_READBACK_EN.
module spi_controller #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  bus,
  output logic             SCLK,
  output logic             nCS,
  output logic             COPI,
  input  logic             CIPO
);

  localparam int unsigned DIV_W   = 8;
  localparam int unsigned BIT_W   = 4;
  localparam int unsigned FRAME_W = 16;
  localparam int unsigned RD_W    = 8;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [BIT_W-1:0] GAP_LAST = BIT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    HOLD,
    GAP
  } state_t;

  state_t                 state;
  logic [DIV_W-1:0]       div_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  // Frame bits not yet on COPI; the bit currently driven lives in copi_q.
  logic [FRAME_W-2:0]     pending;
  logic                   sclk_q;
  logic                   ncs_q;
  logic                   copi_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   done_q;

  wire div_last = (div_cnt == DIV_LAST);

  // Frame sequencer; GAP reuses the bit counter to span two divider periods.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      pending <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      copi_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            pending <= {bus.req_addr, bus.req_data};
            copi_q  <= bus.req_write;
            ncs_q   <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk_q  <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT_HI: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk_q  <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              copi_q  <= pending[FRAME_W-2];
              pending <= {pending[FRAME_W-3:0], 1'b0};
              state   <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        SHIFT_LO: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk_q  <= 1'b1;
            bit_cnt <= bit_cnt + BIT_W'(1);
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (div_last) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            ncs_q   <= 1'b1;
            copi_q  <= 1'b0;
            state   <= GAP;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          if (div_last) begin
            div_cnt <= '0;
            if (bit_cnt == GAP_LAST) begin
              bit_cnt <= '0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign SCLK          = sclk_q;
  assign nCS           = ncs_q;
  assign COPI          = copi_q;
  assign bus.req_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

`ifdef SPI_CTRL_READBACK_EN
  logic [FRAME_W-1:0] rx_shift;
  logic [RD_W-1:0]    rd_q;
  logic [RD_W-1:0]    unused_rx_hi;

  wire sclk_rise = div_last && ((state == SETUP) || (state == SHIFT_LO));
  wire frame_end = div_last && (state == GAP) && (bit_cnt == GAP_LAST);

  // CIPO is captured on the same edge that raises SCLK.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_shift <= '0;
      rd_q     <= '0;
    end else begin
      if (sclk_rise) begin
        rx_shift <= {rx_shift[FRAME_W-2:0], CIPO};
      end
      if (frame_end) begin
        rd_q <= rx_shift[RD_W-1:0];
      end
    end
  end

  assign unused_rx_hi = rx_shift[FRAME_W-1:RD_W];
  assign bus.rd_data  = rd_q;
`else
  logic unused_cipo;

  assign unused_cipo = CIPO;
  assign bus.rd_data = '0;
`endif

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: CLK_DIV=4 instance with a behavioural peripheral,
// plus a CLK_DIV=2 instance for half-period and latency checks.
module tb_spi_controller;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_controller_if bus1();
  spi_controller_if bus2();

  logic sclk1, ncs1, copi1, cipo1;
  logic sclk2, ncs2, copi2;
  logic cipo2 = 1'b0;

  spi_controller #(.CLK_DIV(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .SCLK(sclk1), .nCS(ncs1), .COPI(copi1), .CIPO(cipo1)
  );

  spi_controller #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .SCLK(sclk2), .nCS(ncs2), .COPI(copi2), .CIPO(cipo2)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Peripheral model: decodes write frames to two registers, drives CIPO from miso_pat.
  int          pcnt = 0;
  logic [15:0] psh = '0;
  logic [15:0] miso_pat = '0;
  logic [7:0]  en_reg = '0;
  logic [7:0]  pwm = '0;

  always @(posedge sclk1 or negedge ncs1) begin
    if (sclk1) begin
      psh  = {psh[14:0], copi1};
      pcnt = pcnt + 1;
    end else begin
      pcnt = 0;
    end
  end

  always @(posedge ncs1) begin
    if (pcnt == 16 && psh[15]) begin
      if (psh[14:8] == 7'h00) en_reg = psh[7:0];
      if (psh[14:8] == 7'h04) pwm = psh[7:0];
    end
  end

  assign cipo1 = (pcnt < 16) ? miso_pat[4'(15 - pcnt)] : 1'b0;

  // Monitor for dut1, sampled on the falling clk edge.
  logic        prev_sclk1 = 1'b0, prev_ncs1 = 1'b1;
  int          rises1 = 0, ncs_low1 = 0, gap1 = 0, hi_run1 = 0;
  logic [15:0] bits1 = '0;
  int          done_q1[$];

  always @(negedge clk) begin
    if (prev_ncs1 && !ncs1) begin
      gap1 = hi_run1; rises1 = 0; bits1 = '0; ncs_low1 = 0;
    end
    if (ncs1) hi_run1 = hi_run1 + 1;
    else begin hi_run1 = 0; ncs_low1 = ncs_low1 + 1; end
    if (sclk1 && !prev_sclk1) begin
      rises1 = rises1 + 1; bits1 = {bits1[14:0], copi1};
    end
    if (bus1.done) done_q1.push_back(cyc);
    prev_sclk1 = sclk1; prev_ncs1 = ncs1;
  end

  // Monitor for dut2: SCLK run lengths while nCS is low.
  logic        prev_sclk2 = 1'b0;
  int          rises2 = 0, run2 = 0, min_run2 = 1000, max_run2 = 0;
  logic [15:0] bits2 = '0;
  int          done_q2[$];

  always @(negedge clk) begin
    if (ncs2) run2 = 0;
    else if (sclk2 != prev_sclk2) begin
      if (run2 < min_run2) min_run2 = run2;
      if (run2 > max_run2) max_run2 = run2;
      run2 = 1;
    end else run2 = run2 + 1;
    if (sclk2 && !prev_sclk2) begin
      rises2 = rises2 + 1; bits2 = {bits2[14:0], copi2};
    end
    if (bus2.done) done_q2.push_back(cyc);
    prev_sclk2 = sclk2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send1(input logic w, input logic [6:0] a, input logic [7:0] d, output int acc);
    bit got = 1'b0;
    acc = 0;
    bus1.req_write = w; bus1.req_addr = a; bus1.req_data = d; bus1.req_valid = 1'b1;
    for (int i = 0; i < 1000 && !got; i++) begin
      if (bus1.req_ready) begin acc = cyc + 1; got = 1'b1; end
      tick();
    end
    bus1.req_valid = 1'b0;
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done1(input int n);
    for (int i = 0; i < 2000 && done_q1.size() < n; i++) tick();
    if (done_q1.size() < n) chk("done_timeout", 32'(done_q1.size()), 32'(n));
  endtask

  function automatic int last_done1();
    return (done_q1.size() > 0) ? done_q1[done_q1.size() - 1] : -1;
  endfunction

  initial begin
    int acc, k, nd, acc2;
    int accb[2];
    logic [7:0] exp_rd;

    rst_n = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_write = 1'b0; bus1.req_addr = '0; bus1.req_data = '0;
    bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_ready", 32'(bus1.req_ready), 32'd1);
    chk("rst_busy",  32'(bus1.busy),      32'd0);
    chk("rst_ncs",   32'(ncs1),           32'd1);
    chk("rst_sclk",  32'(sclk1),          32'd0);
    chk("rst_copi",  32'(copi1),          32'd0);
    chk("rst_done",  32'(bus1.done),      32'd0);
    chk("rst_rd",    32'(bus1.rd_data),   32'd0);

    // Single write frame 0x8480.
    send1(1'b1, 7'h04, 8'h80, acc);
    chk("w1_busy_mid", 32'(bus1.busy), 32'd1);
    wait_done1(1);
    chk("w1_bits",    32'(bits1),    32'h8480);
    chk("w1_rises",   32'(rises1),   32'd16);
    chk("w1_ncs_low", 32'(ncs_low1), 32'd132);
    chk("w1_latency", 32'(last_done1() - acc), 32'd140);
    chk("w1_ready",   32'(bus1.req_ready), 32'd1);
    chk("w1_busy",    32'(bus1.busy),      32'd0);
    tick();
    chk("w1_done_pulse", 32'(bus1.done), 32'd0);

    // Loopback writes into the peripheral.
    send1(1'b1, 7'h00, 8'hA5, acc);
    wait_done1(2);
    chk("lb_en_reg", 32'(en_reg), 32'hA5);
    send1(1'b1, 7'h04, 8'h3C, acc);
    wait_done1(3);
    chk("lb_pwm", 32'(pwm), 32'h3C);

    // Back-to-back frames with req_valid held high.
    bus1.req_write = 1'b1; bus1.req_addr = 7'h00; bus1.req_data = 8'h5A; bus1.req_valid = 1'b1;
    k = 0;
    for (int i = 0; i < 2000 && k < 2; i++) begin
      if (bus1.req_ready) begin accb[k] = cyc + 1; k = k + 1; end
      tick();
    end
    bus1.req_valid = 1'b0;
    chk("b2b_accepts", 32'(k), 32'd2);
    wait_done1(5);
    chk("b2b_done_cnt", 32'(done_q1.size()), 32'd5);
    if (done_q1.size() >= 5) begin
      chk("b2b_second_accept", 32'(accb[1]), 32'(done_q1[3] + 1));
      chk("b2b_second_latency", 32'(done_q1[4] - accb[1]), 32'd140);
    end
    chk("b2b_gap_ge9", 32'(gap1 >= 9), 32'd1);
    chk("b2b_en_reg", 32'(en_reg), 32'h5A);

    // Reset after the 7th SCLK rise aborts the frame.
    send1(1'b1, 7'h04, 8'h11, acc);
    for (int i = 0; i < 500 && !(rises1 == 7 && !ncs1); i++) tick();
    chk("abort_reached_bit7", 32'(rises1), 32'd7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_ncs",   32'(ncs1),           32'd1);
    chk("abort_sclk",  32'(sclk1),          32'd0);
    chk("abort_ready", 32'(bus1.req_ready), 32'd1);
    chk("abort_busy",  32'(bus1.busy),      32'd0);
    chk("abort_rd",    32'(bus1.rd_data),   32'd0);
    nd = done_q1.size();
    repeat (200) tick();
    chk("abort_no_done", 32'(done_q1.size()), 32'(nd));
    chk("abort_pwm_kept", 32'(pwm), 32'h3C);
    send1(1'b1, 7'h04, 8'hC3, acc);
    wait_done1(nd + 1);
    chk("post_abort_bits", 32'(bits1), 32'h84C3);
    chk("post_abort_pwm",  32'(pwm),   32'hC3);
    chk("post_abort_latency", 32'(last_done1() - acc), 32'd140);

    // Read frame with the peripheral returning 0x3C in the data phase.
    miso_pat = 16'h003C;
    send1(1'b0, 7'h02, 8'h00, acc);
    wait_done1(nd + 2);
`ifdef SPI_CTRL_READBACK_EN
    exp_rd = 8'h3C;
`else
    exp_rd = 8'h00;
`endif
    chk("rd_bits", 32'(bits1), 32'h0200);
    chk("rd_data", 32'(bus1.rd_data), 32'(exp_rd));
    chk("rd_pwm_untouched", 32'(pwm), 32'hC3);
    miso_pat = 16'h0000;

    // CLK_DIV=2 instance.
    acc2 = 0;
    bus2.req_write = 1'b1; bus2.req_addr = 7'h01; bus2.req_data = 8'hFF; bus2.req_valid = 1'b1;
    for (int i = 0; i < 100 && acc2 == 0; i++) begin
      if (bus2.req_ready) acc2 = cyc + 1;
      tick();
    end
    bus2.req_valid = 1'b0;
    for (int i = 0; i < 500 && done_q2.size() < 1; i++) tick();
    chk("d2_done_cnt", 32'(done_q2.size()), 32'd1);
    if (done_q2.size() >= 1) chk("d2_latency", 32'(done_q2[0] - acc2), 32'd70);
    chk("d2_bits",    32'(bits2),    32'h81FF);
    chk("d2_rises",   32'(rises2),   32'd16);
    chk("d2_min_run", 32'(min_run2), 32'd2);
    chk("d2_max_run", 32'(max_run2), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d tests run", tests);
    $fatal(1);
  end

endmodule
